// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the round-robin arbiter and a shared ALU datapath.
// master = requesters + datapath side, slave = arbiter side.
interface alu_arbiter_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CMD_W = 6;

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [CMD_W-1:0] req0_cmd;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [WIDTH-1:0] req0_c;
   logic [CMD_W-1:0] req1_cmd;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [WIDTH-1:0] req1_c;
   logic [CMD_W-1:0] cmdin;
   logic [WIDTH-1:0] din_1;
   logic [WIDTH-1:0] din_2;
   logic [WIDTH-1:0] din_3;
   logic [WIDTH-1:0] dout_low;
   logic [WIDTH-1:0] dout_high;
   logic             zero;
   logic             error;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_low;
   logic [WIDTH-1:0] rsp_high;
   logic             rsp_zero;
   logic             rsp_error;
   logic             busy;

   modport master (
      output req_valid, req0_cmd, req0_a, req0_b, req0_c,
             req1_cmd, req1_a, req1_b, req1_c,
             dout_low, dout_high, zero, error, rsp_ready,
      input  req_ready, cmdin, din_1, din_2, din_3,
             rsp_valid, rsp_id, rsp_low, rsp_high, rsp_zero, rsp_error, busy
   );

   modport slave (
      input  req_valid, req0_cmd, req0_a, req0_b, req0_c,
             req1_cmd, req1_a, req1_b, req1_c,
             dout_low, dout_high, zero, error, rsp_ready,
      output req_ready, cmdin, din_1, din_2, din_3,
             rsp_valid, rsp_id, rsp_low, rsp_high, rsp_zero, rsp_error, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency ALU datapath.
// One transaction in flight: IDLE accepts, BUSY drives the ALU, RESP holds the result.
module alu_arbiter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned LATENCY = 4
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);
   localparam int unsigned CMD_W = 6;
   localparam int unsigned CNT_W = 4;
   localparam logic [CMD_W-1:0] CMD_NOP = CMD_W'(0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q;
   logic             last_grant_q;
   logic             id_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CMD_W-1:0] cmdin_q;
   logic [WIDTH-1:0] din_1_q;
   logic [WIDTH-1:0] din_2_q;
   logic [WIDTH-1:0] din_3_q;
   logic             rsp_valid_q;
   logic             rsp_id_q;
   logic [WIDTH-1:0] rsp_low_q;
   logic [WIDTH-1:0] rsp_high_q;
   logic             rsp_zero_q;
   logic             rsp_error_q;
   logic             busy_q;
   logic             grant_c;
   logic             accept_c;

   // A lone requester wins; on a tie the one not served last time wins.
   always_comb begin
      grant_c = 1'b0;
      if (bus.req_valid == 2'b10) begin
         grant_c = 1'b1;
      end else if (bus.req_valid == 2'b11) begin
         grant_c = ~last_grant_q;
      end
   end

   assign accept_c      = (state_q == IDLE) && (bus.req_valid != 2'b00) && !rst;
   assign bus.req_ready = accept_c ? (grant_c ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         cnt_q        <= CNT_W'(0);
         cmdin_q      <= CMD_NOP;
         din_1_q      <= WIDTH'(0);
         din_2_q      <= WIDTH'(0);
         din_3_q      <= WIDTH'(0);
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_low_q    <= WIDTH'(0);
         rsp_high_q   <= WIDTH'(0);
         rsp_zero_q   <= 1'b0;
         rsp_error_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  state_q      <= BUSY;
                  busy_q       <= 1'b1;
                  last_grant_q <= grant_c;
                  id_q         <= grant_c;
                  cnt_q        <= CNT_W'(LATENCY - 1);
                  cmdin_q      <= grant_c ? bus.req1_cmd : bus.req0_cmd;
                  din_1_q      <= grant_c ? bus.req1_a   : bus.req0_a;
                  din_2_q      <= grant_c ? bus.req1_b   : bus.req0_b;
                  din_3_q      <= grant_c ? bus.req1_c   : bus.req0_c;
               end
            end
            BUSY: begin
               // Last datapath cycle: result is valid now, so capture and release the ALU.
               if (cnt_q == CNT_W'(0)) begin
                  state_q     <= RESP;
                  cmdin_q     <= CMD_NOP;
                  din_1_q     <= WIDTH'(0);
                  din_2_q     <= WIDTH'(0);
                  din_3_q     <= WIDTH'(0);
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_low_q   <= bus.dout_low;
                  rsp_high_q  <= bus.dout_high;
                  rsp_zero_q  <= bus.zero;
                  rsp_error_q <= bus.error;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmdin     = cmdin_q;
   assign bus.din_1     = din_1_q;
   assign bus.din_2     = din_2_q;
   assign bus.din_3     = din_3_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_low   = rsp_low_q;
   assign bus.rsp_high  = rsp_high_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.rsp_error = rsp_error_q;
   assign bus.busy      = busy_q;

endmodule
